// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the two-requester I2C master controller.
//   - state_t      : controller states (one entry per bus phase)
//   - quarter_t    : index of the SCL quarter-period inside a bit-time
//   - I2C_RD/I2C_WR: values of the R/W bit sent after the 7-bit address
//   - ADDR_W/DATA_W: address and data widths
//   - scl_level / sda_pull: bus level decode for a given state and quarter
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  typedef logic [1:0] quarter_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDR       = 4'd2,
    ST_ADDR_ACK   = 4'd3,
    ST_WDATA      = 4'd4,
    ST_WDATA_ACK  = 4'd5,
    ST_RDATA      = 4'd6,
    ST_RDATA_NACK = 4'd7,
    ST_STOP       = 4'd8,
    ST_DONE       = 4'd9
  } state_t;

  // SCL level for a state/quarter. Data and ACK bits are low in q0-q1 and
  // high in q2-q3; START falls in q3 so the first address bit starts low;
  // STOP rises in q1 so SDA can be released while SCL is high.
  function automatic logic scl_level(input state_t st, input quarter_t q);
    logic lvl;
    case (st)
      ST_START:      lvl = (q != 2'd3);
      ST_STOP:       lvl = (q != 2'd0);
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_NACK: lvl = q[1];
      default:       lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // 1 when the master must pull SDA low. bit_val is the data bit currently
  // being shifted out (only meaningful in ADDR/WDATA).
  function automatic logic sda_pull(input state_t st, input quarter_t q,
                                    input logic bit_val);
    logic pull;
    case (st)
      ST_START: pull = q[1];
      ST_STOP:  pull = ~q[1];
      ST_ADDR,
      ST_WDATA: pull = ~bit_val;
      default:  pull = 1'b0;
    endcase
    return pull;
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: divides the system clock into SCL quarter-periods.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   clear        : holds the divider at quarter 0, count 0 (controller idle)
//   qend         : high on the last clock of every quarter
//   quarter      : current quarter index (q0..q3)
//   quarter_next : quarter index of the next clock, used by the owner to
//                  register bus levels one cycle ahead
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  output logic     qend,
  output quarter_t quarter,
  output quarter_t quarter_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  quarter_t      quarter_q, quarter_d;

  // Next count/quarter: wrap the count at CLK_DIV and advance the quarter.
  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (clear) begin
      cnt_d     = '0;
      quarter_d = 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      cnt_d     = cnt_q + CW'(1);
      quarter_d = quarter_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign qend         = (cnt_q == CNT_MAX);
  assign quarter      = quarter_q;
  assign quarter_next = quarter_d;

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: two-requester round-robin I2C master. Runs one complete
// single-byte transaction per grant: START, address+R/W, ACK, data byte,
// ACK/NACK, STOP.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   req[1:0]                 : request levels, held until the matching done
//   req_addr0/1, req_rw[1:0] : target address and direction (1 = read)
//   req_wdata0/1             : write byte per requester
//   gnt[1:0]                 : one-hot grant, START through the done cycle
//   done[1:0]                : one-cycle completion pulse
//   nack                     : valid with done, address or write data NACKed
//   rdata                    : last read byte, held until the next read
//   busy                     : controller not idle
//   scl                      : push-pull SCL
//   sda                      : open-drain SDA (0 or z)
// Build option: define I2C_NACK_RETRY_EN to retry an address NACK once.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [1:0]        req_rw,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              nack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              scl,
  inout  wire               sda
);

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              nack_flag_q, nack_flag_d;
  logic              sda_smp_q, sda_smp_d;
  logic [1:0]        done_q, done_d;
  logic              nack_q, nack_d;
  logic              busy_q, busy_d;
  logic              scl_q, scl_d;
  logic              sda_low_q, sda_low_d;
`ifdef I2C_NACK_RETRY_EN
  logic              addr_nack_q, addr_nack_d;
  logic              retry_q, retry_d;
`endif

  logic     win;
  logic     qend;
  logic     sample_pt;
  logic     bit_end;
  logic     div_clear;
  logic     sda_in;
  quarter_t quarter;
  quarter_t quarter_next;

  assign div_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign sample_pt = qend && (quarter == 2'd2);
  assign bit_end   = qend && (quarter == 2'd3);
  assign sda_in    = sda;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk          (clk),
    .rst          (rst),
    .clear        (div_clear),
    .qend         (qend),
    .quarter      (quarter),
    .quarter_next (quarter_next)
  );

  // Next-state, datapath and bus-level logic. Bus levels are computed from
  // the next state/quarter so the registered scl/sda line up exactly with
  // the quarter boundaries.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    shreg_d     = shreg_q;
    rdata_d     = rdata_q;
    bit_cnt_d   = bit_cnt_q;
    nack_flag_d = nack_flag_q;
    done_d      = 2'b00;
    nack_d      = 1'b0;
    win         = 1'b0;
`ifdef I2C_NACK_RETRY_EN
    addr_nack_d = addr_nack_q;
    retry_d     = retry_q;
`endif

    if (sample_pt) begin
      sda_smp_d = sda_in;
    end else begin
      sda_smp_d = sda_smp_q;
    end

    case (state_q)
      ST_IDLE: begin
        // With both requesting, serve whoever was not served last.
        if (req == 2'b11) begin
          win = ~last_q;
        end else begin
          win = req[1];
        end
        if (req != 2'b00) begin
          gnt_d       = win ? 2'b10 : 2'b01;
          addr_d      = win ? req_addr1 : req_addr0;
          rw_d        = req_rw[win];
          wdata_d     = win ? req_wdata1 : req_wdata0;
          shreg_d     = {(win ? req_addr1 : req_addr0), req_rw[win]};
          bit_cnt_d   = 3'd0;
          nack_flag_d = 1'b0;
`ifdef I2C_NACK_RETRY_EN
          addr_nack_d = 1'b0;
          retry_d     = 1'b0;
`endif
          state_d     = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_START;
        end
      end

      ST_ADDR, ST_WDATA: begin
        if (bit_end) begin
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WDATA_ACK;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_ADDR_ACK: begin
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          if (!sda_smp_q) begin
            if (rw_q == I2C_RD) begin
              state_d = ST_RDATA;
            end else begin
              shreg_d = wdata_q;
              state_d = ST_WDATA;
            end
          end else begin
            nack_flag_d = 1'b1;
`ifdef I2C_NACK_RETRY_EN
            addr_nack_d = 1'b1;
`endif
            state_d     = ST_STOP;
          end
        end else begin
          state_d = ST_ADDR_ACK;
        end
      end

      ST_WDATA_ACK: begin
        if (bit_end) begin
          nack_flag_d = sda_smp_q;
          state_d     = ST_STOP;
        end else begin
          state_d = ST_WDATA_ACK;
        end
      end

      ST_RDATA: begin
        // Sample point and bit end fall in different quarters, so the last
        // bit is already in shreg_q when the byte is handed to rdata.
        if (sample_pt) begin
          shreg_d = {shreg_q[DATA_W-2:0], sda_in};
          state_d = ST_RDATA;
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rdata_d = shreg_q;
            state_d = ST_RDATA_NACK;
          end else begin
            state_d = ST_RDATA;
          end
        end else begin
          state_d = ST_RDATA;
        end
      end

      ST_RDATA_NACK: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RDATA_NACK;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
`ifdef I2C_NACK_RETRY_EN
          if (addr_nack_q && !retry_q) begin
            retry_d     = 1'b1;
            addr_nack_d = 1'b0;
            nack_flag_d = 1'b0;
            shreg_d     = {addr_q, rw_q};
            bit_cnt_d   = 3'd0;
            state_d     = ST_START;
          end else begin
            done_d  = gnt_q;
            nack_d  = nack_flag_q;
            state_d = ST_DONE;
          end
`else
          done_d  = gnt_q;
          nack_d  = nack_flag_q;
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_STOP;
        end
      end

      ST_DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    scl_d     = scl_level(state_d, quarter_next);
    sda_low_d = sda_pull(state_d, quarter_next, shreg_d[DATA_W-1]);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      addr_q      <= '0;
      rw_q        <= I2C_WR;
      wdata_q     <= '0;
      shreg_q     <= '0;
      rdata_q     <= '0;
      bit_cnt_q   <= 3'd0;
      nack_flag_q <= 1'b0;
      sda_smp_q   <= 1'b1;
      done_q      <= 2'b00;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      shreg_q     <= shreg_d;
      rdata_q     <= rdata_d;
      bit_cnt_q   <= bit_cnt_d;
      nack_flag_q <= nack_flag_d;
      sda_smp_q   <= sda_smp_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      scl_q       <= scl_d;
      sda_low_q   <= sda_low_d;
    end
  end

`ifdef I2C_NACK_RETRY_EN
  // Retry bookkeeping: one automatic retry per grant on an address NACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_nack_q <= 1'b0;
      retry_q     <= 1'b0;
    end else begin
      addr_nack_q <= addr_nack_d;
      retry_q     <= retry_d;
    end
  end
`endif

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign nack  = nack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign scl   = scl_q;
  assign sda   = sda_low_q ? 1'b0 : 1'bz;

endmodule
